sprite_overlay_engine: RTL and testbench

//  Parametrised, pipelined successor to the fixed-position emblem overlay: draws NUM_SPR

---
 rtl/sprite_overlay_engine_if.sv | 30 +++
 rtl/sprite_overlay_engine.sv | 191 +++++++++++++++++++
 tb/tb_sprite_overlay_engine.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_overlay_engine_if.sv
// Raster, config, ROM and overlay-output signals of the sprite overlay engine.
// The master side drives raster/config/ROM data; the slave side is the engine.
interface sprite_overlay_engine_if #(parameter int SPR_W = 48);
  logic [9:0]       x;
  logic             active;
  logic             line_start;
  logic [9:0]       line_y;
  logic             frame_start;
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [1:0]       cfg_field;
  logic [9:0]       cfg_wdata;
  logic             rom_req;
  logic [5:0]       rom_addr;
  logic [SPR_W-1:0] rom_data;
  logic             fetch_busy;
  logic [5:0]       rgb;
  logic             sprite_hit;

  modport master (
    output x, active, line_start, line_y, frame_start,
    output cfg_we, cfg_sel, cfg_field, cfg_wdata, rom_data,
    input  rom_req, rom_addr, fetch_busy, rgb, sprite_hit
  );
  modport slave (
    input  x, active, line_start, line_y, frame_start,
    input  cfg_we, cfg_sel, cfg_field, cfg_wdata, rom_data,
    output rom_req, rom_addr, fetch_busy, rgb, sprite_hit
  );
endinterface

// File: rtl/sprite_overlay_engine.sv
// NUM_SPR-channel 1-bpp sprite overlay: hblank row prefetch into line buffers,
// lowest-index-wins pixel resolve, shadow config committed at frame_start.
module sprite_overlay_engine #(
  parameter int          NUM_SPR     = 3,
  parameter int          SPR_W       = 48,
  parameter int          SPR_H       = 45,
  parameter int          SCALE_LOG2  = 0,
  parameter int          BLINK_BIT   = 4,
  parameter logic [5:0]  COLOR_TRANS = 6'b100001
) (
  input  logic                    clk,
  input  logic                    rst,
  sprite_overlay_engine_if.slave  bus
);
  localparam int          IW     = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int          CW     = $clog2(SPR_W);
  localparam int          FW     = BLINK_BIT + 1;
  localparam logic [10:0] SPAN_Y = 11'(SPR_H << SCALE_LOG2);
  localparam logic [10:0] SPAN_X = 11'(SPR_W << SCALE_LOG2);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] col;
    logic       blink;
    logic       en;
  } spr_cfg_t;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT} state_t;

  spr_cfg_t                         r_shadow [NUM_SPR];
  spr_cfg_t                         r_live   [NUM_SPR];
  spr_cfg_t                         w_sh_nxt [NUM_SPR];
  logic [FW-1:0]                    r_fcnt;
  state_t                           r_state, w_state_nxt;
  logic [IW-1:0]                    r_idx, w_idx_nxt;
  logic [9:0]                       r_line_y;
  logic [NUM_SPR-1:0]               r_valid;
  logic [NUM_SPR-1:0][SPR_W-1:0]    r_buf;
  logic [5:0]                       r_rgb;
  logic                             r_hit;

  // A write landing on the frame_start cycle must reach the live copy too,
  // so the commit takes the post-write shadow value.
  always_comb begin
    for (int i = 0; i < NUM_SPR; i++) begin
      w_sh_nxt[i] = r_shadow[i];
      if (bus.cfg_we && (int'(bus.cfg_sel) == i)) begin
        case (bus.cfg_field)
          2'd0:    w_sh_nxt[i].x   = bus.cfg_wdata;
          2'd1:    w_sh_nxt[i].y   = bus.cfg_wdata;
          2'd2:    w_sh_nxt[i].col = bus.cfg_wdata[5:0];
          default: {w_sh_nxt[i].blink, w_sh_nxt[i].en} = bus.cfg_wdata[1:0];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        r_shadow[i] <= '0;
        r_live[i]   <= '0;
      end
      r_fcnt <= '0;
    end else begin
      for (int i = 0; i < NUM_SPR; i++) r_shadow[i] <= w_sh_nxt[i];
      if (bus.frame_start) begin
        for (int i = 0; i < NUM_SPR; i++) r_live[i] <= w_sh_nxt[i];
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  spr_cfg_t    w_cur;
  logic [10:0] w_dy;
  logic        w_vis, w_last, w_rom_req, w_buf_we, w_clr_one;
  logic [5:0]  w_rom_addr;

  assign w_cur  = r_live[r_idx];
  assign w_dy   = {1'b0, r_line_y} - {1'b0, w_cur.y};
  assign w_vis  = w_cur.en && !(w_cur.blink && r_fcnt[BLINK_BIT]) && !w_dy[10] && (w_dy < SPAN_Y);
  assign w_last = (r_idx == IW'(NUM_SPR - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rom_req   = 1'b0;
    w_rom_addr  = '0;
    w_buf_we    = 1'b0;
    w_clr_one   = 1'b0;
    case (r_state)
      S_CHECK: begin
        if (w_vis) begin
          w_rom_req   = 1'b1;
          w_rom_addr  = 6'(w_dy >> SCALE_LOG2);
          w_state_nxt = S_WAIT;
        end else begin
          w_clr_one = 1'b1;
          if (w_last) w_state_nxt = S_IDLE;
          else        w_idx_nxt   = r_idx + 1'b1;
        end
      end
      S_WAIT: begin
        w_buf_we = 1'b1;
        if (w_last) w_state_nxt = S_IDLE;
        else begin
          w_state_nxt = S_CHECK;
          w_idx_nxt   = r_idx + 1'b1;
        end
      end
      default: ;
    endcase
    // A new line always wins, even over an in-flight fetch.
    if (bus.line_start) begin
      w_state_nxt = S_CHECK;
      w_idx_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_y <= '0;
      r_valid  <= '0;
    end else if (bus.line_start) begin
      r_line_y <= bus.line_y;
      r_valid  <= '0;
    end else if (w_clr_one) begin
      r_valid[r_idx] <= 1'b0;
    end else if (w_buf_we) begin
      r_valid[r_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_we && !bus.line_start) r_buf[r_idx] <= bus.rom_data;
  end

  logic [NUM_SPR-1:0] w_pix;
  for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
    logic [10:0]   w_dx;
    logic [CW-1:0] w_col;
    logic          w_in;
    assign w_dx     = {1'b0, bus.x} - {1'b0, r_live[g].x};
    assign w_in     = r_valid[g] && !w_dx[10] && (w_dx < SPAN_X);
    assign w_col    = CW'(w_dx >> SCALE_LOG2);
    assign w_pix[g] = w_in && r_buf[g][w_col];
  end

  logic       w_any;
  logic [5:0] w_col_out;
  always_comb begin
    w_any     = 1'b0;
    w_col_out = COLOR_TRANS;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (w_pix[i]) begin
        w_any     = 1'b1;
        w_col_out = r_live[i].col;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb <= COLOR_TRANS;
      r_hit <= 1'b0;
    end else if (bus.active && w_any) begin
      r_rgb <= w_col_out;
      r_hit <= 1'b1;
    end else begin
      r_rgb <= COLOR_TRANS;
      r_hit <= 1'b0;
    end
  end

  assign bus.rom_req    = w_rom_req;
  assign bus.rom_addr   = w_rom_addr;
  assign bus.fetch_busy = (r_state != S_IDLE);
  assign bus.rgb        = r_rgb;
  assign bus.sprite_hit = r_hit;
endmodule

// File: tb/tb_sprite_overlay_engine.sv
// Drives a 1x and a 2x-scaled engine with identical raster/config stimulus and
// checks fetches and pixels against a line-level reference model.
module tb_sprite_overlay_engine;
  localparam int NS = 3;
  localparam int W  = 48;
  localparam int H  = 45;
  localparam int TR = 'h21;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [9:0] x, line_y, cfg_wdata;
  logic       active, line_start, frame_start, cfg_we;
  logic [1:0] cfg_sel, cfg_field;

  sprite_overlay_engine_if #(.SPR_W(W)) bus0 ();
  sprite_overlay_engine_if #(.SPR_W(W)) bus1 ();

  assign bus0.x = x;                   assign bus1.x = x;
  assign bus0.active = active;         assign bus1.active = active;
  assign bus0.line_start = line_start; assign bus1.line_start = line_start;
  assign bus0.line_y = line_y;         assign bus1.line_y = line_y;
  assign bus0.frame_start = frame_start; assign bus1.frame_start = frame_start;
  assign bus0.cfg_we = cfg_we;         assign bus1.cfg_we = cfg_we;
  assign bus0.cfg_sel = cfg_sel;       assign bus1.cfg_sel = cfg_sel;
  assign bus0.cfg_field = cfg_field;   assign bus1.cfg_field = cfg_field;
  assign bus0.cfg_wdata = cfg_wdata;   assign bus1.cfg_wdata = cfg_wdata;

  sprite_overlay_engine #(.NUM_SPR(NS), .SPR_W(W), .SPR_H(H), .SCALE_LOG2(0), .BLINK_BIT(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  sprite_overlay_engine #(.NUM_SPR(NS), .SPR_W(W), .SPR_H(H), .SCALE_LOG2(1), .BLINK_BIT(0))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  logic [W-1:0] rom [64];
  always @(posedge clk) begin
    bus0.rom_data <= rom[bus0.rom_addr];
    bus1.rom_data <= rom[bus1.rom_addr];
  end

  int cap0[$], cap1[$];
  always @(negedge clk) begin
    if (bus0.rom_req) cap0.push_back(int'(bus0.rom_addr));
    if (bus1.rom_req) cap1.push_back(int'(bus1.rom_addr));
  end

  int checks = 0, failures = 0;

  // Reference model: config copies, frame count and the per-line fetch result.
  int sh_x[NS], sh_y[NS], sh_c[NS], sh_ctl[NS];
  int lv_x[NS], lv_y[NS], lv_c[NS], lv_ctl[NS];
  int fcnt;
  bit vis[2][NS];
  int row[2][NS];

  function automatic logic [5:0] get_rgb(int d); return d ? bus1.rgb : bus0.rgb; endfunction
  function automatic logic get_hit(int d);  return d ? bus1.sprite_hit : bus0.sprite_hit; endfunction
  function automatic logic get_busy(int d); return d ? bus1.fetch_busy : bus0.fetch_busy; endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_c[i] = 0; sh_ctl[i] = 0;
      lv_x[i] = 0; lv_y[i] = 0; lv_c[i] = 0; lv_ctl[i] = 0;
      vis[0][i] = 0; vis[1][i] = 0;
    end
    fcnt = 0;
  endfunction

  function automatic void model_write(int sel, int fld, int data);
    if (sel >= NS) return;
    case (fld)
      0: sh_x[sel] = data % 1024;
      1: sh_y[sel] = data % 1024;
      2: sh_c[sel] = data % 64;
      default: sh_ctl[sel] = data % 4;
    endcase
  endfunction

  function automatic void model_line(int y);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NS; i++) begin
        int dy = y - lv_y[i];
        bit on = (lv_ctl[i] % 2) == 1;
        bit blanked = ((lv_ctl[i] / 2) % 2 == 1) && (fcnt % 2 == 1);
        vis[d][i] = on && !blanked && dy >= 0 && dy < (H << d);
        row[d][i] = vis[d][i] ? (dy >> d) : 0;
      end
  endfunction

  // Returns winning colour, or -1 when the pixel is transparent.
  function automatic int exp_pix(int d, int xv, bit act);
    if (!act) return -1;
    for (int i = 0; i < NS; i++) begin
      int dx = xv - lv_x[i];
      if (vis[d][i] && dx >= 0 && dx < (W << d) && rom[row[d][i]][dx >> d]) return lv_c[i];
    end
    return -1;
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic cfg_write(int sel, int fld, int data);
    cfg_we = 1'b1; cfg_sel = sel[1:0]; cfg_field = fld[1:0]; cfg_wdata = data[9:0];
    tick();
    cfg_we = 1'b0;
    model_write(sel, fld, data);
  endtask

  task automatic frame(bit wr, int sel, int fld, int data);
    frame_start = 1'b1;
    cfg_we = wr; cfg_sel = sel[1:0]; cfg_field = fld[1:0]; cfg_wdata = data[9:0];
    tick();
    frame_start = 1'b0; cfg_we = 1'b0;
    if (wr) model_write(sel, fld, data);
    for (int i = 0; i < NS; i++) begin
      lv_x[i] = sh_x[i]; lv_y[i] = sh_y[i]; lv_c[i] = sh_c[i]; lv_ctl[i] = sh_ctl[i];
    end
    fcnt++;
  endtask

  task automatic set_spr(int sel, int xv, int yv, int c, int ctl);
    cfg_write(sel, 0, xv); cfg_write(sel, 1, yv); cfg_write(sel, 2, c); cfg_write(sel, 3, ctl);
  endtask

  task automatic pulse_line(int y);
    line_start = 1'b1; line_y = y[9:0];
    tick();
    line_start = 1'b0;
  endtask

  // Called in the first CHECK cycle; pre[d] >= 0 is an aborted address expected first.
  task automatic wait_fetch(int pre0, int pre1);
    for (int d = 0; d < 2; d++) begin
      int exp_q[$];
      int got_q[$];
      int cost = 0;
      int pre = d ? pre1 : pre0;
      if (pre >= 0) exp_q.push_back(pre);
      for (int i = 0; i < NS; i++) begin
        cost += vis[d][i] ? 2 : 1;
        if (vis[d][i]) exp_q.push_back(row[d][i]);
      end
      if (d == 0) begin
        int n = -1;
        for (int k = 0; k <= 4 * NS; k++) begin
          if (!get_busy(0) && n < 0) n = k;
          if (!get_busy(0) && !get_busy(1)) break;
          tick();
        end
        checks++;
        if (n != cost) begin
          failures++;
          $display("FAIL fetch_cycles dut0: got %0d expected %0d", n, cost);
        end
      end
      got_q = d ? cap1 : cap0;
      checks++;
      if (got_q != exp_q) begin
        failures++;
        $display("FAIL rom_addr_seq dut%0d: got %p expected %p", d, got_q, exp_q);
      end
    end
    checks++;
    if (get_busy(1) !== 1'b0) begin
      failures++;
      $display("FAIL fetch_busy_end dut1: got %b expected 0", get_busy(1));
    end
  endtask

  task automatic do_line(int y);
    cap0.delete(); cap1.delete();
    pulse_line(y);
    model_line(y);
    wait_fetch(-1, -1);
  endtask

  task automatic check_px(int xv, bit act);
    x = xv[9:0]; active = act;
    tick();
    for (int d = 0; d < 2; d++) begin
      int e = exp_pix(d, xv, act);
      logic [5:0] er = (e < 0) ? 6'(TR) : 6'(e);
      logic eh = (e >= 0);
      checks++;
      if (get_rgb(d) !== er || get_hit(d) !== eh) begin
        failures++;
        $display("FAIL pixel dut%0d x=%0d act=%0b: got rgb=%b hit=%b expected rgb=%b hit=%b",
                 d, xv, act, get_rgb(d), get_hit(d), er, eh);
      end
    end
  endtask

  task automatic check_idle_outputs(string name);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (get_rgb(d) !== 6'b100001 || get_hit(d) !== 1'b0 || get_busy(d) !== 1'b0 ||
          (d ? bus1.rom_req : bus0.rom_req) !== 1'b0 || (d ? bus1.rom_addr : bus0.rom_addr) !== 6'd0) begin
        failures++;
        $display("FAIL %s dut%0d: got rgb=%b hit=%b busy=%b req=%b expected rgb=100001 hit=0 busy=0 req=0",
                 name, d, get_rgb(d), get_hit(d), get_busy(d), d ? bus1.rom_req : bus0.rom_req);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    model_reset();
    check_idle_outputs("reset_state");
    set_spr(0, 100, 50, 6'b001100, 1);
    frame(0, 0, 0, 0);
    pulse_line(60);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    model_reset();
    tick();
    check_idle_outputs("reset_mid_fetch");
    do_line(60);
    check_px(105, 1);
  endtask

  task automatic test_basic();
    rom[5][3] = 1'b1;
    set_spr(0, 260, 160, 6'b100100, 1);
    frame(0, 0, 0, 0);
    do_line(165);
    checks++;
    if (cap0.size() != 1 || cap0[0] != 5) begin
      failures++; $display("FAIL basic_rom_addr dut0: got %p expected '{5}", cap0);
    end
    check_px(263, 1);
    checks++;
    if (bus0.rgb !== 6'b100100 || bus0.sprite_hit !== 1'b1) begin
      failures++; $display("FAIL basic_x263 dut0: got %b/%b expected 100100/1", bus0.rgb, bus0.sprite_hit);
    end
    check_px(259, 1);
    checks++;
    if (bus0.rgb !== 6'b100001) begin
      failures++; $display("FAIL basic_x259 dut0: got %b expected 100001", bus0.rgb);
    end
    check_px(263, 0);
    for (int xv = 255; xv < 360; xv += 3) check_px(xv, 1);
  endtask

  task automatic test_overlap();
    rom[10] = '1; rom[5] = '1;
    set_spr(0, 300, 200, 6'b100100, 1);
    set_spr(1, 300, 200, 6'b010010, 1);
    frame(0, 0, 0, 0);
    do_line(210);
    check_px(305, 1);
    checks++;
    if (bus0.rgb !== 6'b100100 || bus0.sprite_hit !== 1'b1) begin
      failures++; $display("FAIL overlap_prio dut0: got %b/%b expected 100100/1", bus0.rgb, bus0.sprite_hit);
    end
    for (int xv = 296; xv < 400; xv += 7) check_px(xv, 1);
    frame(1, 0, 3, 0);
    do_line(210);
    for (int xv = 296; xv < 400; xv += 7) check_px(xv, 1);
  endtask

  task automatic test_scale();
    rom[44][47] = 1'b1;
    set_spr(0, 400, 100, 6'b000111, 1);
    cfg_write(1, 3, 0);
    frame(0, 0, 0, 0);
    do_line(189);
    checks++;
    if (cap1.size() != 1 || cap1[0] != 44) begin
      failures++; $display("FAIL scale_rom_addr dut1: got %p expected '{44}", cap1);
    end
    check_px(495, 1);
    checks++;
    if (bus1.rgb !== 6'b000111 || bus1.sprite_hit !== 1'b1) begin
      failures++; $display("FAIL scale_col47 dut1: got %b/%b expected 000111/1", bus1.rgb, bus1.sprite_hit);
    end
    check_px(496, 1);
    do_line(190);
    checks++;
    if (cap1.size() != 0) begin
      failures++; $display("FAIL scale_no_req dut1: got %p expected empty", cap1);
    end
    check_px(495, 1);
  endtask

  task automatic test_shadow();
    cfg_write(0, 0, 50);
    do_line(110);
    check_px(420, 1);
    check_px(60, 1);
    frame(1, 0, 2, 6'b110000);
    do_line(110);
    check_px(60, 1);
    checks++;
    if (bus0.rgb !== 6'b110000) begin
      failures++; $display("FAIL shadow_commit dut0: got %b expected 110000", bus0.rgb);
    end
    check_px(420, 1);
  endtask

  task automatic test_blink();
    cfg_write(0, 3, 3);
    for (int f = 0; f < 4; f++) begin
      frame(0, 0, 0, 0);
      do_line(110);
      check_px(60, 1);
      checks++;
      if (bus0.sprite_hit !== (fcnt % 2 == 0)) begin
        failures++; $display("FAIL blink dut0 fcnt=%0d: got hit=%b expected %b", fcnt, bus0.sprite_hit, fcnt % 2 == 0);
      end
    end
    set_spr(1, 300, 100, 6'b011011, 1);
    frame(1, 0, 3, 1);
    cap0.delete(); cap1.delete();
    pulse_line(110);
    model_line(110);
    tick();
    pulse_line(110);
    wait_fetch(row[0][0], row[1][0]);
    check_px(60, 1);
    check_px(310, 1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 150; it++) begin
      int nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) begin
        int sel = $urandom_range(0, 3);
        int fld = $urandom_range(0, 3);
        int data;
        if (fld == 0)      data = ($urandom_range(0, 4) == 0) ? $urandom_range(980, 1023) : $urandom_range(0, 1023);
        else if (fld == 1) data = ($urandom_range(0, 4) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 200);
        else               data = $urandom_range(0, 1023);
        cfg_write(sel, fld, data);
      end
      if ($urandom_range(0, 1) == 1) frame($urandom_range(0, 1) == 1, $urandom_range(0, 3), 3, $urandom_range(0, 3));
      do_line(($urandom_range(0, 4) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 250));
      for (int p = 0; p < 12; p++) begin
        int i  = $urandom_range(0, NS - 1);
        int xv = lv_x[i] + $urandom_range(0, 100) - 4;
        if (xv < 0) xv = 0;
        if (xv > 1023) xv = 1023;
        check_px(xv, $urandom_range(0, 9) != 0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = {16'($urandom()), 32'($urandom())};
    x = '0; active = 1'b0; line_start = 1'b0; line_y = '0; frame_start = 1'b0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_field = '0; cfg_wdata = '0; rst = 1'b1;
    model_reset();
    tick();
    test_reset();
    test_basic();
    test_overlap();
    test_scale();
    test_shadow();
    test_blink();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
